// File: rtl/sw_io_pkg.sv
// Shared constants for the switch-input IO register window.
package sw_io_pkg;

    localparam int unsigned IO_DW = 32;

    localparam logic [3:0] SW_VALUE_OFS  = 4'h0;
    localparam logic [3:0] SW_CHANGE_OFS = 4'h4;
    localparam logic [3:0] SW_MASK_OFS   = 4'h8;
    localparam logic [3:0] SW_RAW_OFS    = 4'hC;

    // Word index of a byte offset within the window.
    function automatic logic [1:0] sw_reg_idx(input logic [3:0] ofs);
        return ofs[3:2];
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch line: 2-flop synchroniser, sample history and debounced level.
// With SW_RAW_READ_EN defined the synchronised level is also exported.
module sw_debounce_bit #(
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic sw_i,
    input  logic tick_i,
`ifdef SW_RAW_READ_EN
    output logic sync_o,
`endif
    output logic stable_o,
    output logic stable_next_o
);

    logic                      r_sync1;
    logic                      r_sync2;
    logic                      r_stable;
    logic [STABLE_SAMPLES-2:0] r_hist;
    logic [STABLE_SAMPLES-1:0] w_window;
    logic                      w_stable_next;

    // The current synchronised level completes the window of older samples.
    assign w_window = {r_hist, r_sync2};

    always_comb begin
        w_stable_next = r_stable;
        if (tick_i) begin
            if (&w_window) begin
                w_stable_next = 1'b1;
            end else if (~|w_window) begin
                w_stable_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_hist   <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync1  <= sw_i;
            r_sync2  <= r_sync1;
            if (tick_i) begin
                r_hist <= w_window[STABLE_SAMPLES-2:0];
            end
            r_stable <= w_stable_next;
        end
    end

`ifdef SW_RAW_READ_EN
    assign sync_o = r_sync2;
`endif
    assign stable_o      = r_stable;
    assign stable_next_o = w_stable_next;

endmodule

// File: rtl/sw_input_ctrl.sv
// Debounced switch input peripheral with VALUE/CHANGE/MASK registers and change irq.
// Define SW_RAW_READ_EN to expose the synchronised raw switch value at offset 0xC.
module sw_input_ctrl
    import sw_io_pkg::*;
#(
    parameter int unsigned SW_WIDTH       = 24,
    parameter int unsigned SAMPLE_DIV     = 100000,
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic [SW_WIDTH-1:0] sw_i,
    input  logic [3:0]          io_addr,
    input  logic                io_re,
    input  logic                io_we,
    input  logic [IO_DW-1:0]    io_wdata,
    output logic [IO_DW-1:0]    io_rdata,
    output logic [SW_WIDTH-1:0] sw_stable_o,
    output logic                irq_o
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

    logic [CNT_W-1:0]    r_cnt;
    logic [SW_WIDTH-1:0] r_change;
    logic [SW_WIDTH-1:0] r_mask;
    logic                r_irq;

    logic                w_tick;
    logic [SW_WIDTH-1:0] w_stable;
    logic [SW_WIDTH-1:0] w_stable_next;
    logic [SW_WIDTH-1:0] w_clr;
    logic [SW_WIDTH-1:0] w_change_next;
    logic [SW_WIDTH-1:0] w_mask_next;
    logic                w_wr_change;
    logic                w_wr_mask;
    logic                w_unused;
`ifdef SW_RAW_READ_EN
    logic [SW_WIDTH-1:0] w_sync;
`endif

    assign w_tick = (r_cnt == CNT_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < SW_WIDTH; g++) begin : g_bit
        sw_debounce_bit #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_bit (
            .clk_i        (clk_i),
            .rst_n        (rst_n),
            .sw_i         (sw_i[g]),
            .tick_i       (w_tick),
`ifdef SW_RAW_READ_EN
            .sync_o       (w_sync[g]),
`endif
            .stable_o     (w_stable[g]),
            .stable_next_o(w_stable_next[g])
        );
    end

    assign w_wr_change = io_we && (sw_reg_idx(io_addr) == sw_reg_idx(SW_CHANGE_OFS));
    assign w_wr_mask   = io_we && (sw_reg_idx(io_addr) == sw_reg_idx(SW_MASK_OFS));
    assign w_clr       = w_wr_change ? io_wdata[SW_WIDTH-1:0] : '0;

    // A hardware set in the same cycle as a W1C of that bit wins.
    assign w_change_next = (r_change & ~w_clr) | (w_stable_next ^ w_stable);
    assign w_mask_next   = w_wr_mask ? io_wdata[SW_WIDTH-1:0] : r_mask;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_change <= '0;
            r_mask   <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_change <= w_change_next;
            r_mask   <= w_mask_next;
            r_irq    <= |(w_change_next & w_mask_next);
        end
    end

    always_comb begin
        io_rdata = '0;
        if (io_re) begin
            case (sw_reg_idx(io_addr))
                sw_reg_idx(SW_VALUE_OFS):  io_rdata = IO_DW'(w_stable);
                sw_reg_idx(SW_CHANGE_OFS): io_rdata = IO_DW'(r_change);
                sw_reg_idx(SW_MASK_OFS):   io_rdata = IO_DW'(r_mask);
`ifdef SW_RAW_READ_EN
                sw_reg_idx(SW_RAW_OFS):    io_rdata = IO_DW'(w_sync);
`endif
                default:                   io_rdata = '0;
            endcase
        end
    end

    // Byte-lane bits and unimplemented write-data bits have no function.
    assign w_unused = ^{io_addr[1:0], io_wdata};

    assign sw_stable_o = w_stable;
    assign irq_o       = r_irq;

endmodule

// File: tb/tb_sw_input_ctrl.sv
// Self-checking bench for sw_input_ctrl against a sample-counting reference model.
module tb_sw_input_ctrl;

    localparam int W = 24;
    localparam int D = 4;
    localparam int S = 3;

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic [W-1:0]  sw_i;
    logic [3:0]    io_addr;
    logic          io_re;
    logic          io_we;
    logic [31:0]   io_wdata;
    logic [31:0]   io_rdata;
    logic [W-1:0]  sw_stable_o;
    logic          irq_o;

    sw_input_ctrl #(
        .SW_WIDTH      (W),
        .SAMPLE_DIV    (D),
        .STABLE_SAMPLES(S)
    ) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .sw_i       (sw_i),
        .io_addr    (io_addr),
        .io_re      (io_re),
        .io_we      (io_we),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .sw_stable_o(sw_stable_o),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: cycle index since reset, samples taken so far, register contents.
    int           m_cyc;
    logic [W-1:0] m_samp[$];
    logic [W-1:0] m_stable, m_change, m_mask, m_p1, m_p2;
    logic         m_irq;
    logic         n_tick;
    logic [W-1:0] n_stable, n_change, n_mask;
    logic         n_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_samp = {};
        for (int k = 0; k < S; k++) m_samp.push_back('0);
        m_stable = '0; m_change = '0; m_mask = '0; m_p1 = '0; m_p2 = '0; m_irq = 1'b0;
    endtask

    function automatic logic [31:0] model_rdata();
        if (!io_re) return 32'h0;
        case (io_addr[3:2])
            2'd0: return {8'h0, m_stable};
            2'd1: return {8'h0, m_change};
            2'd2: return {8'h0, m_mask};
`ifdef SW_RAW_READ_EN
            default: return {8'h0, m_p2};
`else
            default: return 32'h0;
`endif
        endcase
    endfunction

    // Pin level seen by the debouncer now is the pin level two cycles ago.
    task automatic model_next();
        logic [W-1:0] clr;
        n_tick   = (m_cyc % D) == D - 1;
        n_stable = m_stable;
        if (n_tick) begin
            for (int b = 0; b < W; b++) begin
                int ones = m_p2[b];
                for (int k = 1; k < S; k++) ones += m_samp[k][b];
                if (ones == S) n_stable[b] = 1'b1;
                else if (ones == 0) n_stable[b] = 1'b0;
            end
        end
        clr      = (io_we && io_addr[3:2] == 2'd1) ? io_wdata[W-1:0] : '0;
        n_mask   = (io_we && io_addr[3:2] == 2'd2) ? io_wdata[W-1:0] : m_mask;
        n_change = (m_change & ~clr) | (n_stable ^ m_stable);
        n_irq    = |(n_change & n_mask);
    endtask

    task automatic model_commit();
        if (n_tick) begin
            m_samp.push_back(m_p2);
            void'(m_samp.pop_front());
        end
        m_stable = n_stable; m_change = n_change; m_mask = n_mask; m_irq = n_irq;
        m_p2 = m_p1;
        m_p1 = sw_i;
        m_cyc++;
    endtask

    // One clock: check combinational read, advance model, check registered outputs.
    task automatic step();
        #1;
        chk("rdata", io_rdata, model_rdata());
        model_next();
        @(posedge clk_i);
        #1;
        model_commit();
        chk("stable", {8'h0, sw_stable_o}, {8'h0, m_stable});
        chk("irq", {31'h0, irq_o}, {31'h0, m_irq});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus_idle();
        io_re = 1'b0; io_we = 1'b0; io_addr = 4'h0; io_wdata = 32'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        io_we = 1'b1; io_re = 1'b0; io_addr = a; io_wdata = d;
        step();
        bus_idle();
    endtask

    task automatic read_lit(input string name, input logic re, input logic [3:0] a,
                            input logic [31:0] exp);
        io_we = 1'b0; io_re = re; io_addr = a;
        #1;
        chk(name, io_rdata, exp);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_stable", {8'h0, sw_stable_o}, 32'h0);
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        io_re = 1'b1; io_addr = 4'h4;
        #1;
        chk("rst_change", io_rdata, 32'h0);
        bus_idle();
        @(posedge clk_i);
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit done;
        logic [W-1:0] exp_val;
        bus_idle();
        sw_i  = 24'hFFFFFF;
        rst_n = 1'b0;
        model_reset();

        // Reset with all switches high, then three ticks of samples.
        #2;
        chk("rst0_stable", {8'h0, sw_stable_o}, 32'h0);
        chk("rst0_irq", {31'h0, irq_o}, 32'h0);
        io_re = 1'b1;
        #1;
        chk("rst0_rdata", io_rdata, 32'h0);
        bus_idle();
        @(posedge clk_i);
        #2;
        rst_n = 1'b1;
        run(2 + S * D - 2);
        read_lit("t1_value", 1'b1, 4'h0, 32'h00FFFFFF);
        read_lit("t1_change", 1'b1, 4'h4, 32'h00FFFFFF);
        step();
        bus_idle();

        // Bounce on bit 0 never passes the filter.
        sw_i[0] = 1'b0;
        run(20);
        wr(4'h4, 32'hFFFFFFFF);
        exp_val = m_stable;
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) sw_i[0] = ~sw_i[0];
            step();
        end
        chk("bounce_value", {8'h0, sw_stable_o}, {8'h0, exp_val});
        read_lit("bounce_change", 1'b1, 4'h4, 32'h0);
        bus_idle();
        sw_i[0] = 1'b1;
        run(2 + S * D + 1);
        read_lit("bounce_rise", 1'b1, 4'h0, 32'h00FFFFFF);
        read_lit("bounce_chg0", 1'b1, 4'h4, 32'h1);
        step();
        bus_idle();

        // Masked interrupt on bit 0; unmasked bit 5 stays silent.
        sw_i[0] = 1'b0;
        run(20);
        wr(4'h4, 32'hFFFFFFFF);
        wr(4'h8, 32'h1);
        sw_i[0] = 1'b1;
        for (int i = 0; i < 40 && !sw_stable_o[0]; i++) step();
        chk("irq_bit0_rose", {31'h0, sw_stable_o[0]}, 32'h1);
        chk("irq_set", {31'h0, irq_o}, 32'h1);
        wr(4'h4, 32'h1);
        chk("irq_clr", {31'h0, irq_o}, 32'h0);
        sw_i[5] = ~sw_i[5];
        run(20);
        chk("irq_bit5_masked", {31'h0, irq_o}, 32'h0);

        // W1C colliding with a fresh bit-3 transition.
        wr(4'h4, 32'hFFFFFFFF);
        sw_i[3] = ~sw_i[3];
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            model_next();
            if (n_stable[3] != m_stable[3]) begin
                wr(4'h4, 32'h8);
                done = 1'b1;
            end else begin
                step();
            end
        end
        chk("collide_found", {31'h0, done}, 32'h1);
        read_lit("collide_change", 1'b1, 4'h4, 32'h8);
        bus_idle();
        run(20);

        // Register map corners.
        wr(4'h8, 32'hFFFFFFFF);
        read_lit("mask_impl", 1'b1, 4'h8, 32'h00FFFFFF);
        bus_idle();
        wr(4'h0, 32'h12345678);
        read_lit("value_ro", 1'b1, 4'h1, {8'h0, sw_i});
`ifdef SW_RAW_READ_EN
        read_lit("raw_read", 1'b1, 4'hC, {8'h0, sw_i});
`else
        read_lit("raw_read", 1'b1, 4'hC, 32'h0);
`endif
        read_lit("re_low", 1'b0, 4'h8, 32'h0);
        step();
        bus_idle();

        // Mid-debounce asynchronous reset with CHANGE = 0x5.
        wr(4'h4, 32'hFFFFFFFF);
        sw_i[0] = ~sw_i[0];
        sw_i[2] = ~sw_i[2];
        run(20);
        read_lit("pre_rst_change", 1'b1, 4'h4, 32'h5);
        bus_idle();
        sw_i[1] = ~sw_i[1];
        run(5);
        reset_pulse();
        run(2 + S * D + 1);
        read_lit("post_rst_value", 1'b1, 4'h0, {8'h0, sw_i});
        step();
        bus_idle();

        // Randomised pins and bus traffic.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) sw_i[$urandom_range(W - 1)] ^= 1'b1;
            io_re    = 1'($urandom_range(1));
            io_addr  = 4'($urandom_range(15));
            io_we    = ($urandom_range(5) == 0);
            io_wdata = $urandom;
            step();
        end
        bus_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
